// File: rtl/mesh_writer.sv
// ============================================================================
// Module      : mesh_writer
// Description : Assembles framed byte-stream records into index and position
//               memory writes for the vertex fetch stage, and appends the
//               12'hFFF terminator entry on end-of-mesh.
//               Optional feature macro: MESH_WRITER_CHECKSUM_EN (adds a
//               trailing XOR checksum byte to index/position records).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_writer #(
  parameter int         ADDR_WIDTH   = 12,
  parameter logic [7:0] HDR_INDEX    = 8'h49,
  parameter logic [7:0] HDR_POSITION = 8'h50,
  parameter logic [7:0] HDR_END      = 8'h45,
  parameter logic [7:0] HDR_RESTART  = 8'h52
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  output logic                  index_we_out,
  output logic [ADDR_WIDTH-1:0] index_addr_out,
  output logic [2:0][11:0]      index_data_out,
  output logic                  position_we_out,
  output logic [ADDR_WIDTH-1:0] position_addr_out,
  output logic [2:0][31:0]      position_data_out,
  output logic [ADDR_WIDTH:0]   index_count_out,
  output logic [ADDR_WIDTH:0]   position_count_out,
  output logic                  done_out,
  output logic                  overflow_out,
  output logic [7:0]            checksum_err_out
);

  // Index memory keeps its top slot for the terminator; position memory may fill completely.
  localparam logic [ADDR_WIDTH:0] INDEX_FULL = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] POS_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_HEADER  = 3'd0,
    ST_PAYLOAD = 3'd1,
`ifdef MESH_WRITER_CHECKSUM_EN
    ST_CHECK   = 3'd2,
`endif
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state;
  logic        is_pos;     // current record is a position record
  logic        is_term;    // current write is the end-of-mesh terminator
  logic [3:0]  byte_cnt;   // payload byte index within the record
  logic [95:0] asm_buf;    // little-endian payload assembly buffer
  logic [95:0] next_buf;
  logic [95:0] rec_data;
  logic        accept;
  logic        last_byte;
  logic        commit;
  logic        rec_full;
  logic        restart;
`ifdef MESH_WRITER_CHECKSUM_EN
  logic [7:0]  csum;       // running XOR of header and payload bytes
`endif

  assign accept    = byte_valid_in & byte_ready_out;
  assign last_byte = is_pos ? (byte_cnt == 4'd11) : (byte_cnt == 4'd4);
  assign rec_full  = is_pos ? (position_count_out == POS_FULL)
                            : (index_count_out == INDEX_FULL);
  assign restart   = accept && (byte_in == HDR_RESTART) &&
                     ((state == ST_HEADER) || (state == ST_DONE));

`ifndef MESH_WRITER_CHECKSUM_EN
  assign checksum_err_out = 8'h00;
`endif

  // Drop the incoming byte into its little-endian slot of the assembly buffer.
  always_comb begin
    next_buf = asm_buf;
    next_buf[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  // Decide when a complete, valid record is ready to be written and which data it carries.
  always_comb begin
    commit   = 1'b0;
    rec_data = asm_buf;
    if (state == ST_PAYLOAD) begin
      rec_data = next_buf;
`ifndef MESH_WRITER_CHECKSUM_EN
      commit   = accept && last_byte;
`endif
    end
`ifdef MESH_WRITER_CHECKSUM_EN
    if (state == ST_CHECK) begin
      commit = accept && (byte_in == csum);
    end
`endif
  end

  // Record framing FSM with registered strobes, addresses, data and status.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= ST_HEADER;
      is_pos             <= 1'b0;
      is_term            <= 1'b0;
      byte_cnt           <= 4'd0;
      asm_buf            <= '0;
      byte_ready_out     <= 1'b1;
      index_we_out       <= 1'b0;
      index_addr_out     <= '0;
      index_data_out     <= '0;
      position_we_out    <= 1'b0;
      position_addr_out  <= '0;
      position_data_out  <= '0;
      index_count_out    <= '0;
      position_count_out <= '0;
      done_out           <= 1'b0;
      overflow_out       <= 1'b0;
`ifdef MESH_WRITER_CHECKSUM_EN
      csum               <= 8'h00;
      checksum_err_out   <= 8'h00;
`endif
    end else begin
      case (state)
        ST_HEADER: begin
          if (accept) begin
            byte_cnt <= 4'd0;
`ifdef MESH_WRITER_CHECKSUM_EN
            csum     <= byte_in;
`endif
            if (byte_in == HDR_INDEX) begin
              is_pos <= 1'b0;
              state  <= ST_PAYLOAD;
            end else if (byte_in == HDR_POSITION) begin
              is_pos <= 1'b1;
              state  <= ST_PAYLOAD;
            end else if (byte_in == HDR_END) begin
              // Terminator is written whenever a slot exists (count below depth).
              is_term        <= 1'b1;
              index_addr_out <= index_count_out[ADDR_WIDTH-1:0];
              index_data_out <= {12'hFFF, 12'h000, 12'h000};
              index_we_out   <= ~index_count_out[ADDR_WIDTH];
              byte_ready_out <= 1'b0;
              state          <= ST_WRITE;
            end
          end
        end

        ST_PAYLOAD: begin
          if (accept) begin
            asm_buf  <= next_buf;
            byte_cnt <= byte_cnt + 4'd1;
`ifdef MESH_WRITER_CHECKSUM_EN
            csum     <= csum ^ byte_in;
            if (last_byte) begin
              state <= ST_CHECK;
            end
`endif
          end
        end

`ifdef MESH_WRITER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept && !commit) begin
            if (checksum_err_out != 8'hFF) begin
              checksum_err_out <= checksum_err_out + 8'd1;
            end
            state <= ST_HEADER;
          end
        end
`endif

        ST_WRITE: begin
          // Strobe lasts one cycle; the count advances as it drops.
          index_we_out    <= 1'b0;
          position_we_out <= 1'b0;
          byte_ready_out  <= 1'b1;
          if (index_we_out) begin
            index_count_out <= index_count_out + CNT_ONE;
          end
          if (position_we_out) begin
            position_count_out <= position_count_out + CNT_ONE;
          end
          if (is_term) begin
            is_term  <= 1'b0;
            done_out <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_HEADER;
          end
        end

        ST_DONE: begin
          // Everything except a restart header is swallowed here.
        end

        default: begin
          state <= ST_HEADER;
        end
      endcase

      if (restart) begin
        index_count_out    <= '0;
        position_count_out <= '0;
        done_out           <= 1'b0;
        overflow_out       <= 1'b0;
        state              <= ST_HEADER;
      end

      if (commit) begin
        if (rec_full) begin
          // Record is consumed but dropped; flag it and wait for the next header.
          overflow_out <= 1'b1;
          state        <= ST_HEADER;
        end else begin
          byte_ready_out <= 1'b0;
          state          <= ST_WRITE;
          if (is_pos) begin
            position_we_out   <= 1'b1;
            position_addr_out <= position_count_out[ADDR_WIDTH-1:0];
            position_data_out <= {rec_data[95:64], rec_data[63:32], rec_data[31:0]};
          end else begin
            index_we_out   <= 1'b1;
            index_addr_out <= index_count_out[ADDR_WIDTH-1:0];
            index_data_out <= {rec_data[35:24], rec_data[23:12], rec_data[11:0]};
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
